// File: rtl/wbuf_pkg.sv
// Shared constants, types and helpers for the ping-pong weight buffer.
// Kernel-size clamping and squaring live here so every unit agrees on them.
package wbuf_pkg;

  localparam int DATA_WIDTH      = 16;
  localparam int KERNEL_SIZE_MAX = 5;
  localparam int SLICES_PER_BANK = 64;
  localparam int KS_W            = 3;
  localparam int NWORDS          = KERNEL_SIZE_MAX * KERNEL_SIZE_MAX;
  localparam int SLICE_AW        = $clog2(SLICES_PER_BANK);
  localparam int ELEM_AW         = $clog2(NWORDS);

  localparam logic [SLICE_AW:0] FC_MAX = (SLICE_AW+1)'(SLICES_PER_BANK);

  typedef logic [KS_W-1:0]       ks_t;
  typedef logic [ELEM_AW:0]      ksq_t;
  typedef logic [DATA_WIDTH-1:0] word_t;

  typedef struct packed {
    logic valid;
    logic bank;
    logic zero;
  } rd_req_t;

  function automatic ks_t ks_clamp(input ks_t ks);
    if (ks == '0 || ks > KS_W'(KERNEL_SIZE_MAX))
      return KS_W'(KERNEL_SIZE_MAX);
    return ks;
  endfunction

  function automatic ksq_t ks_sq(input ks_t ks);
    ksq_t k;
    k = ksq_t'(ks_clamp(ks));
    return k * k;
  endfunction

endpackage

// File: rtl/weight_buffer_pingpong_if.sv
// Loader/reader bundle of the ping-pong weight buffer.
// master = loader+reader side, slave = buffer.
interface weight_buffer_pingpong_if;
  import wbuf_pkg::*;

  ks_t                          cfg_ks;
  logic                         ena_w;
  logic [SLICE_AW-1:0]          addr_write;
  logic [NWORDS*DATA_WIDTH-1:0] din;
  logic                         fill_done;
  logic                         wr_ready;
  logic                         wr_err;
  logic [SLICE_AW:0]            fill_count;
  logic                         ena_r;
  logic [SLICE_AW+ELEM_AW-1:0]  addr_read;
  logic                         rd_avail;
  logic                         rd_release;
  word_t                        dout;
  logic                         rd_valid;

  modport master (
    output cfg_ks, ena_w, addr_write, din, fill_done,
    output ena_r, addr_read, rd_release,
    input  wr_ready, wr_err, fill_count,
    input  rd_avail, dout, rd_valid
  );

  modport slave (
    input  cfg_ks, ena_w, addr_write, din, fill_done,
    input  ena_r, addr_read, rd_release,
    output wr_ready, wr_err, fill_count,
    output rd_avail, dout, rd_valid
  );

endinterface

// File: rtl/wbuf_bank_ram.sv
// One weight bank: whole-slice write with per-element zero mask,
// single-word registered read.
module wbuf_bank_ram
  import wbuf_pkg::*;
(
  input  logic                         clk,
  input  logic                         we,
  input  logic [SLICE_AW-1:0]          waddr,
  input  logic [NWORDS*DATA_WIDTH-1:0] wdata,
  input  logic [NWORDS-1:0]            wkeep,
  input  logic                         re,
  input  logic [SLICE_AW-1:0]          rslice,
  input  logic [ELEM_AW-1:0]           relem,
  output word_t                        rdata
);

  word_t mem_q [SLICES_PER_BANK][NWORDS];
  word_t rdata_q;
  word_t rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (re)
      rdata_d = mem_q[rslice][relem];
  end

  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
    if (we) begin
      for (int e = 0; e < NWORDS; e++)
        mem_q[waddr][e] <= wkeep[e] ?
          wdata[e*DATA_WIDTH +: DATA_WIDTH] : '0;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/weight_buffer_pingpong.sv
// Ping-pong weight buffer: loader fills one bank while the conv
// datapath reads the other; ownership moves via fill_done/rd_release.
module weight_buffer_pingpong
  import wbuf_pkg::*;
(
  input logic                     clk,
  input logic                     rst,
  weight_buffer_pingpong_if.slave bus
);

  logic [1:0]        full_q, full_d;
  logic              fill_sel_q, fill_sel_d;
  logic              act_sel_q, act_sel_d;
  ks_t               ks_q, ks_d;
  logic [SLICE_AW:0] fill_count_q, fill_count_d;
  logic              wr_err_q, wr_err_d;
  rd_req_t           rd_q, rd_d;

  logic                wr_ready, rd_avail;
  logic                wr_acc, fd_acc, rel_acc, rd_go, in_range;
  ksq_t                ksq;
  logic [NWORDS-1:0]   wkeep;
  logic [SLICE_AW-1:0] rd_slice;
  logic [ELEM_AW-1:0]  rd_elem;
  logic [1:0]          we, re;
  word_t               rdata [2];

  assign wr_ready = !full_q[fill_sel_q];
  assign rd_avail = full_q[act_sel_q];

  assign wr_acc  = bus.ena_w && wr_ready;
  assign fd_acc  = bus.fill_done && wr_ready;
  assign rel_acc = bus.rd_release && rd_avail;
  assign rd_go   = bus.ena_r && rd_avail;

  assign ksq      = ks_sq(ks_q);
  assign rd_slice = bus.addr_read[SLICE_AW+ELEM_AW-1 -: SLICE_AW];
  assign rd_elem  = bus.addr_read[ELEM_AW-1:0];
  assign in_range = (int'(rd_slice) < SLICES_PER_BANK) &&
                    ({1'b0, rd_elem} < ksq);

  always_comb begin
    wkeep = '0;
    for (int e = 0; e < NWORDS; e++)
      wkeep[e] = ksq_t'(e) < ksq;
  end

  // Out-of-range reads never touch the RAM; they return zero.
  always_comb begin
    we = '0;
    re = '0;
    we[fill_sel_q] = wr_acc;
    re[act_sel_q]  = rd_go && in_range;
  end

  always_comb begin
    full_d       = full_q;
    fill_sel_d   = fill_sel_q ^ fd_acc;
    act_sel_d    = act_sel_q ^ rel_acc;
    fill_count_d = fill_count_q;
    ks_d         = ks_q;
    wr_err_d     = (bus.ena_w || bus.fill_done) && !wr_ready;
    rd_d         = rd_q;
    if (fd_acc)
      full_d[fill_sel_q] = 1'b1;
    if (rel_acc)
      full_d[act_sel_q] = 1'b0;
    if (fd_acc)
      fill_count_d = '0;
    else if (wr_acc && fill_count_q < FC_MAX)
      fill_count_d = fill_count_q + (SLICE_AW+1)'(1);
    if (full_q == '0 && fill_count_q == '0)
      ks_d = ks_clamp(bus.cfg_ks);
    rd_d.valid = rd_go;
    if (rd_go) begin
      rd_d.bank = act_sel_q;
      rd_d.zero = !in_range;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q       <= '0;
      fill_sel_q   <= 1'b0;
      act_sel_q    <= 1'b0;
      ks_q         <= KS_W'(KERNEL_SIZE_MAX);
      fill_count_q <= '0;
      wr_err_q     <= 1'b0;
      rd_q         <= '{valid: 1'b0, bank: 1'b0, zero: 1'b1};
    end else begin
      full_q       <= full_d;
      fill_sel_q   <= fill_sel_d;
      act_sel_q    <= act_sel_d;
      ks_q         <= ks_d;
      fill_count_q <= fill_count_d;
      wr_err_q     <= wr_err_d;
      rd_q         <= rd_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    wbuf_bank_ram u_ram (
      .clk    (clk),
      .we     (we[b]),
      .waddr  (bus.addr_write),
      .wdata  (bus.din),
      .wkeep  (wkeep),
      .re     (re[b]),
      .rslice (rd_slice),
      .relem  (rd_elem),
      .rdata  (rdata[b])
    );
  end

  assign bus.wr_ready   = wr_ready;
  assign bus.rd_avail   = rd_avail;
  assign bus.wr_err     = wr_err_q;
  assign bus.fill_count = fill_count_q;
  assign bus.rd_valid   = rd_q.valid;
  assign bus.dout       = rd_q.zero ? '0 : rdata[rd_q.bank];

endmodule

// File: tb/tb_weight_buffer_pingpong.sv
// Bench for weight_buffer_pingpong: read vector table, scoreboard of
// expected read data, and directed ping-pong/reset sequences.
module tb_weight_buffer_pingpong;
  import wbuf_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  weight_buffer_pingpong_if bus ();

  weight_buffer_pingpong dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          s;
    int          e;
    logic        v;
    logic [15:0] d;
  } exp_t;

  exp_t  sb[$];
  exp_t  tbl[8];
  int    n_total = 0;
  int    n_pass  = 0;
  logic [15:0] last_dout = 16'h0;

  function automatic logic [15:0] pat(int tag, int s, int e);
    return 16'h3C00 | 16'(tag << 14) | 16'(s << 6) | 16'(e);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic idle();
    bus.ena_w      = 1'b0;
    bus.fill_done  = 1'b0;
    bus.ena_r      = 1'b0;
    bus.rd_release = 1'b0;
  endtask

  task automatic step();
    exp_t x;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      chk($sformatf("rd_valid[%0d,%0d]", x.s, x.e),
          32'(bus.rd_valid), 32'(x.v));
      chk($sformatf("rd_dout[%0d,%0d]", x.s, x.e),
          32'(bus.dout), 32'(x.d));
    end
    idle();
  endtask

  task automatic set_wr(int s, int tag);
    bus.ena_w      = 1'b1;
    bus.addr_write = SLICE_AW'(s);
    for (int e = 0; e < NWORDS; e++)
      bus.din[e*DATA_WIDTH +: DATA_WIDTH] = pat(tag, s, e);
  endtask

  task automatic set_rd(int s, int e, logic v, logic [15:0] d);
    exp_t x;
    bus.ena_r     = 1'b1;
    bus.addr_read = {SLICE_AW'(s), ELEM_AW'(e)};
    x = '{s: s, e: e, v: v, d: d};
    sb.push_back(x);
    if (v) last_dout = d;
  endtask

  task automatic wr(int s, int tag);
    set_wr(s, tag);
    step();
  endtask

  task automatic rd(int s, int e, logic [15:0] d);
    set_rd(s, e, 1'b1, d);
    step();
  endtask

  task automatic fd();
    bus.fill_done = 1'b1;
    step();
  endtask

  task automatic rel();
    bus.rd_release = 1'b1;
    step();
  endtask

  initial begin
    tbl[0] = '{s: 0, e: 4,  v: 1'b1, d: 16'h3C04};
    tbl[1] = '{s: 0, e: 0,  v: 1'b1, d: 16'h3C00};
    tbl[2] = '{s: 0, e: 8,  v: 1'b1, d: 16'h3C08};
    tbl[3] = '{s: 0, e: 9,  v: 1'b1, d: 16'h0000};
    tbl[4] = '{s: 0, e: 10, v: 1'b1, d: 16'h0000};
    tbl[5] = '{s: 0, e: 31, v: 1'b1, d: 16'h0000};
    tbl[6] = '{s: 1, e: 3,  v: 1'b1, d: pat(3, 1, 3)};
    tbl[7] = '{s: 1, e: 8,  v: 1'b1, d: pat(3, 1, 8)};

    idle();
    bus.cfg_ks     = 3'd5;
    bus.addr_write = '0;
    bus.din        = '0;
    bus.addr_read  = '0;
    step();
    step();
    chk("rst_wr_ready", 32'(bus.wr_ready), 1);
    chk("rst_rd_avail", 32'(bus.rd_avail), 0);
    chk("rst_fill_count", 32'(bus.fill_count), 0);
    chk("rst_wr_err", 32'(bus.wr_err), 0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 0);
    chk("rst_dout", 32'(bus.dout), 0);
    rst = 1'b0;

    // fill bank0 with ks=3, slice1 rewritten
    bus.cfg_ks = 3'd3;
    step();
    wr(0, 0);
    wr(1, 1);
    wr(1, 3);
    chk("fill_count_3", 32'(bus.fill_count), 3);
    fd();
    chk("b0_rd_avail", 32'(bus.rd_avail), 1);
    chk("b0_wr_ready", 32'(bus.wr_ready), 1);
    chk("b0_fill_count", 32'(bus.fill_count), 0);

    for (int i = 0; i < 8; i++) begin
      set_rd(tbl[i].s, tbl[i].e, tbl[i].v, tbl[i].d);
      step();
    end

    // fill bank1 while reading bank0
    set_wr(0, 2);
    set_rd(0, 4, 1'b1, 16'h3C04);
    step();
    wr(5, 2);
    fd();
    chk("both_wr_ready", 32'(bus.wr_ready), 0);
    chk("both_rd_avail", 32'(bus.rd_avail), 1);
    chk("both_fill_count", 32'(bus.fill_count), 0);

    // rejected write and fill_done
    wr(0, 1);
    chk("rej_wr_err", 32'(bus.wr_err), 1);
    chk("rej_fill_count", 32'(bus.fill_count), 0);
    step();
    chk("rej_wr_err_drop", 32'(bus.wr_err), 0);
    fd();
    chk("rej_fd_wr_err", 32'(bus.wr_err), 1);
    chk("rej_fd_wr_ready", 32'(bus.wr_ready), 0);
    rd(0, 4, 16'h3C04);
    rd(0, 0, 16'h3C00);

    // ks change held off while a bank is owned
    bus.cfg_ks = 3'd5;
    set_rd(0, 4, 1'b1, 16'h3C04);
    bus.rd_release = 1'b1;
    step();
    chk("rel1_rd_avail", 32'(bus.rd_avail), 1);
    chk("rel1_wr_ready", 32'(bus.wr_ready), 1);
    rd(0, 4, pat(2, 0, 4));
    rd(5, 8, pat(2, 5, 8));
    rd(5, 9, 16'h0000);

    // write + fill_done + release in one cycle
    set_wr(3, 1);
    bus.fill_done  = 1'b1;
    bus.rd_release = 1'b1;
    step();
    chk("swap_rd_avail", 32'(bus.rd_avail), 1);
    chk("swap_wr_ready", 32'(bus.wr_ready), 1);
    chk("swap_fill_count", 32'(bus.fill_count), 0);
    rd(3, 9, 16'h0000);
    rd(3, 8, pat(1, 3, 8));

    rel();
    chk("empty_rd_avail", 32'(bus.rd_avail), 0);
    chk("empty_wr_ready", 32'(bus.wr_ready), 1);
    set_rd(3, 8, 1'b0, last_dout);
    step();

    // ks now 5: full slice kept
    wr(0, 0);
    fd();
    rd(0, 24, pat(0, 0, 24));
    rd(0, 9, pat(0, 0, 9));
    rel();

    // cfg_ks=0 clamps to 5
    bus.cfg_ks = 3'd3;
    step();
    bus.cfg_ks = 3'd0;
    step();
    wr(1, 1);
    fd();
    rd(1, 20, pat(1, 1, 20));

    // reset with both banks full and a read in flight
    set_wr(0, 2);
    bus.fill_done = 1'b1;
    step();
    chk("pre_rst_wr_ready", 32'(bus.wr_ready), 0);
    set_rd(1, 20, 1'b0, 16'h0000);
    rst = 1'b1;
    step();
    chk("mid_rst_rd_avail", 32'(bus.rd_avail), 0);
    chk("mid_rst_wr_ready", 32'(bus.wr_ready), 1);
    chk("mid_rst_fill_count", 32'(bus.fill_count), 0);
    chk("mid_rst_wr_err", 32'(bus.wr_err), 0);
    rst = 1'b0;

    // fill_count saturation
    bus.cfg_ks = 3'd5;
    step();
    for (int i = 0; i < 64; i++)
      wr(i, 0);
    chk("sat_fill_count_64", 32'(bus.fill_count), 64);
    wr(7, 1);
    chk("sat_fill_count_65", 32'(bus.fill_count), 64);
    chk("sat_wr_err", 32'(bus.wr_err), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/weight_buffer_pingpong.md
Name: weight_buffer_pingpong

Overview:
Parametrised successor to the float16 weight RAM. Stores convolution weights as kernel slices, packed KERNEL_SIZE_MAX² words per write. Two banks run as a ping-pong pair, so the loader fills one bank while the conv datapath reads the other. Runtime kernel size, a bank-ownership handshake, a registered read with valid, and explicit error/fill status are new relative to the previous generation.

Parameters:
DATA_WIDTH, 16, weight word width (float16 bit pattern; never interpreted).
KERNEL_SIZE_MAX, 5, maximum kernel edge; one slice = KERNEL_SIZE_MAX² words.
SLICES_PER_BANK, 64, slices held per bank.
KS_W, 3, width of the runtime kernel-size field; must hold KERNEL_SIZE_MAX.
SLICE_AW, clog2(SLICES_PER_BANK), slice address width (derived).
ELEM_AW, clog2(KERNEL_SIZE_MAX²), element address width (derived).

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
cfg_ks  in  KS_W  runtime kernel edge, 1..KERNEL_SIZE_MAX
ena_w  in  1  slice write strobe
addr_write  in  SLICE_AW  slice index in the fill bank
din  in  KERNEL_SIZE_MAX²·DATA_WIDTH  packed slice; element e at bits [e·DATA_WIDTH +: DATA_WIDTH]
fill_done  in  1  pulse: fill bank complete, hand it to the reader
wr_ready  out  1  fill bank is free to write
wr_err  out  1  one-cycle pulse: write or fill_done rejected
fill_count  out  SLICE_AW+1  slice writes accepted into the current fill bank
ena_r  in  1  read strobe
addr_read  in  SLICE_AW+ELEM_AW  {slice, element} in the active bank
rd_avail  out  1  active bank holds valid weights
rd_release  in  1  pulse: reader is done with the active bank
dout  out  DATA_WIDTH  read data
rd_valid  out  1  dout is valid this cycle

Behaviour:
- Storage: 2 banks × SLICES_PER_BANK rows × KERNEL_SIZE_MAX² words. RAM contents are not cleared by reset.
- State: full[1:0], fill_sel, act_sel, ks_reg, fill_count.
- Reset: full=0, fill_sel=0, act_sel=0, ks_reg=KERNEL_SIZE_MAX, fill_count=0, dout=0, rd_valid=0, wr_err=0.
- wr_ready = !full[fill_sel]. rd_avail = full[act_sel]. Both are combinational from registers.
- ks_reg loads cfg_ks only in cycles where full==0 and fill_count==0. cfg_ks values of 0 or above KERNEL_SIZE_MAX clamp to KERNEL_SIZE_MAX.
- Write accepted when ena_w && wr_ready:
  - elements e < ks_reg² are written from din;
  - elements e ≥ ks_reg² are written as 0;
  - fill_count increments and saturates at SLICES_PER_BANK;
  - rewriting the same slice is allowed, overwrites, and still increments fill_count.
- Write with !wr_ready: no RAM change; wr_err=1 for the next cycle.
- fill_done with wr_ready: full[fill_sel]←1, fill_sel toggles, fill_count←0.
- fill_done with !wr_ready: ignored, and wr_err pulses.
- ena_w and fill_done in the same cycle: the write lands in the bank being closed, then the handover happens; fill_count←0.
- rd_release with rd_avail: full[act_sel]←0 and act_sel toggles. rd_release without rd_avail is ignored.
- fill_done and rd_release in the same cycle always refer to different banks, so both take effect.
- Read latency is 1 cycle: ena_r && rd_avail at cycle N gives dout and rd_valid=1 at cycle N+1.
  - The element field is checked against ks_reg² at request time; if it is ≥ ks_reg², dout=0 with rd_valid=1.
  - A slice index ≥ SLICES_PER_BANK also returns 0.
  - ena_r with !rd_avail: rd_valid=0 and dout holds its previous value.
- rd_release in the same cycle as ena_r: the read uses the old act_sel.
- Reset mid-operation: all flags drop in the following cycle and both banks are treated as empty. A pending read returns nothing (rd_valid=0).

Decomposition:
- Package wbuf_pkg holds DATA_WIDTH, KERNEL_SIZE_MAX, the derived widths, and a function computing ks² with clamping.
- Sub-module wbuf_bank_ram: one bank with a wide masked write and a single-word registered read. Instantiate it twice; the top holds the ping-pong control and the output mux.

Test Plan:
- Reset, then cfg_ks=3; write slice 0 with din elements = 0x3C00+e; fill_done; read {0,4} → dout=0x3C04 one cycle later; read {0,10} → 0x0000 with rd_valid=1.
- Ping-pong: fill bank0 then fill_done, fill bank1 while reading bank0 → bank0 reads are unaffected; a third fill attempt → wr_ready=0, wr_err pulse, no RAM change.
- Release ordering: rd_release → rd_avail stays 1 with act_sel=1 and reads return bank1 data; second rd_release → rd_avail=0, ena_r gives rd_valid=0 and dout unchanged.
- Simultaneous fill_done and rd_release in one cycle → full flags swap correctly and fill_count=0.
- cfg_ks changed to 5 while a bank is full → ks_reg stays 3; after both banks are released it becomes 5. cfg_ks=0 → clamps to 5.
- Assert rst while both banks are full and a read is in flight → next cycle rd_avail=0, wr_ready=1, rd_valid=0, fill_count=0.
